// File: rtl/anneal_pkg.sv
// anneal_pkg: shared phase width, phase type and terminal phase for the schedule and the run controller
package anneal_pkg;
    localparam int STEP_W = 4;
    typedef logic [STEP_W-1:0] step_t;
    localparam step_t LAST_STEP = 4'd10;
endpackage

// File: rtl/sched_iter_cnt.sv
// sched_iter_cnt: iteration counter 0..CYCLES_PER_STEP-1 that advances while en && !freeze.
// Ports: clk, rst_sys (sync, active-high), en, freeze; at_zero (iter==0, ANNEAL_RUNTIME_CFG_EN only);
// wrap (combinational, high on the enabled cycle whose edge returns iter to 0).
module sched_iter_cnt #(
    parameter int CYCLES_PER_STEP = 100
) (
    input  logic clk,
    input  logic rst_sys,
    input  logic en,
    input  logic freeze,
`ifdef ANNEAL_RUNTIME_CFG_EN
    output logic at_zero,
`endif
    output logic wrap
);
    localparam int CW = CYCLES_PER_STEP > 1 ? $clog2(CYCLES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_STEP - 1);
    logic [CW-1:0] iter;
    logic run;
    assign run  = en && !freeze;
    assign wrap = run && iter == LAST;
`ifdef ANNEAL_RUNTIME_CFG_EN
    assign at_zero = iter == '0;
`endif
    always_ff @(posedge clk) begin
        if (rst_sys)
            iter <= '0;
        else if (run)
            iter <= wrap ? '0 : iter + 1'b1;
    end
endmodule

// File: rtl/anneal_sched.sv
// anneal_sched: annealing schedule generator stepping phase 0..10 with per-phase i0 (noise) and q (coupling).
// Ports: clk, rst_sys (sync, active-high), comp_enable (advance while high);
// state_signal (phase), i0, q, step_tick (pulse with each new phase), sched_done (phase == LAST_STEP).
// Macro ANNEAL_RUNTIME_CFG_EN adds cfg_i0_init, cfg_i0_dec, cfg_q_inc, latched while idle at phase 0 / iter 0.
module anneal_sched
    import anneal_pkg::*;
#(
    parameter int              CYCLES_PER_STEP = 100,
    parameter int              I0_W            = 8,
    parameter int              Q_W             = 8,
    parameter logic [I0_W-1:0] I0_INIT         = 8'd200,
    parameter logic [I0_W-1:0] I0_DEC          = 8'd20,
    parameter logic [Q_W-1:0]  Q_INIT          = 8'd0,
    parameter logic [Q_W-1:0]  Q_INC           = 8'd3
) (
    input  logic            clk,
    input  logic            rst_sys,
    input  logic            comp_enable,
`ifdef ANNEAL_RUNTIME_CFG_EN
    input  logic [I0_W-1:0] cfg_i0_init,
    input  logic [I0_W-1:0] cfg_i0_dec,
    input  logic [Q_W-1:0]  cfg_q_inc,
`endif
    output step_t           state_signal,
    output logic [I0_W-1:0] i0,
    output logic [Q_W-1:0]  q,
    output logic            step_tick,
    output logic            sched_done
);
    logic            adv;
    logic            freeze;
    logic [I0_W-1:0] i0_dec_v;
    logic [Q_W-1:0]  q_inc_v;
    logic [I0_W-1:0] i0_nxt;
    logic [Q_W:0]    q_sum;
    logic [Q_W-1:0]  q_nxt;

    assign freeze     = state_signal == LAST_STEP;
    assign sched_done = freeze;

`ifdef ANNEAL_RUNTIME_CFG_EN
    logic            at_zero;
    logic            cfg_load;
    logic [I0_W-1:0] i0_dec_r;
    logic [Q_W-1:0]  q_inc_r;
    // Only an idle schedule sitting at its very start may be reconfigured.
    assign cfg_load = !comp_enable && state_signal == '0 && at_zero;
    assign i0_dec_v = i0_dec_r;
    assign q_inc_v  = q_inc_r;
    always_ff @(posedge clk) begin
        if (rst_sys) begin
            i0_dec_r <= I0_DEC;
            q_inc_r  <= Q_INC;
        end else if (cfg_load) begin
            i0_dec_r <= cfg_i0_dec;
            q_inc_r  <= cfg_q_inc;
        end
    end
`else
    assign i0_dec_v = I0_DEC;
    assign q_inc_v  = Q_INC;
`endif

    sched_iter_cnt #(.CYCLES_PER_STEP(CYCLES_PER_STEP)) u_cnt (
        .clk    (clk),
        .rst_sys(rst_sys),
        .en     (comp_enable),
        .freeze (freeze),
`ifdef ANNEAL_RUNTIME_CFG_EN
        .at_zero(at_zero),
`endif
        .wrap   (adv)
    );

    // One extra bit on both sides keeps the floor/ceiling checks free of wrap-around.
    always_comb begin
        i0_nxt = ({1'b0, i0} >= {1'b0, i0_dec_v}) ? i0 - i0_dec_v : '0;
        q_sum  = {1'b0, q} + {1'b0, q_inc_v};
        q_nxt  = q_sum[Q_W] ? '1 : q_sum[Q_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst_sys) begin
            state_signal <= '0;
            i0           <= I0_INIT;
            q            <= Q_INIT;
            step_tick    <= 1'b0;
        end else begin
            step_tick <= adv;
            if (adv) begin
                state_signal <= state_signal + 1'b1;
                i0           <= i0_nxt;
                q            <= q_nxt;
            end
`ifdef ANNEAL_RUNTIME_CFG_EN
            else if (cfg_load)
                i0 <= cfg_i0_init;
`endif
        end
    end
endmodule

// File: tb/tb_anneal_sched.sv
// tb_anneal_sched: directed self-checking bench for anneal_sched
module tb_anneal_sched;
    import anneal_pkg::*;
    logic       clk = 1'b0;
    logic       rst_sys = 1'b1;
    logic       comp_enable = 1'b0;
    step_t      state_signal, state2;
    logic [7:0] i0, q, i0_2, q_2;
    logic       step_tick, sched_done, tick2, done2;
    int         n_checks = 0;
    int         n_fail = 0;
    int         ticks;
`ifdef ANNEAL_RUNTIME_CFG_EN
    logic [7:0] cfg_i0_init = 8'd200;
    logic [7:0] cfg_i0_dec  = 8'd20;
`endif

    always #5 clk = ~clk;

    anneal_sched #(.CYCLES_PER_STEP(4)) dut (
        .clk         (clk),
        .rst_sys     (rst_sys),
        .comp_enable (comp_enable),
`ifdef ANNEAL_RUNTIME_CFG_EN
        .cfg_i0_init (cfg_i0_init),
        .cfg_i0_dec  (cfg_i0_dec),
        .cfg_q_inc   (8'd3),
`endif
        .state_signal(state_signal),
        .i0          (i0),
        .q           (q),
        .step_tick   (step_tick),
        .sched_done  (sched_done)
    );

    anneal_sched #(.CYCLES_PER_STEP(1), .I0_DEC(8'd30), .Q_INIT(8'd250)) dut_sat (
        .clk         (clk),
        .rst_sys     (rst_sys),
        .comp_enable (comp_enable),
`ifdef ANNEAL_RUNTIME_CFG_EN
        .cfg_i0_init (8'd200),
        .cfg_i0_dec  (8'd30),
        .cfg_q_inc   (8'd3),
`endif
        .state_signal(state2),
        .i0          (i0_2),
        .q           (q_2),
        .step_tick   (tick2),
        .sched_done  (done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_sys = 1'b1;
        comp_enable = 1'b0;
        cyc(1);
        rst_sys = 1'b0;
    endtask

    logic [7:0] sat_i0 [10] = '{170, 140, 110, 80, 50, 20, 0, 0, 0, 0};
    logic [7:0] sat_q  [10] = '{253, 255, 255, 255, 255, 255, 255, 255, 255, 255};

    initial begin
        cyc(2);
        do_reset();
        check("rst_state", 32'(state_signal), 0);
        check("rst_i0", 32'(i0), 200);
        check("rst_q", 32'(q), 0);
        check("rst_tick", 32'(step_tick), 0);
        check("rst_done", 32'(sched_done), 0);

        // full run
        comp_enable = 1'b1;
        ticks = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc(1);
            ticks += int'(step_tick);
            if (c % 4 == 0) begin
                check("run_state", 32'(state_signal), 32'(c / 4));
                check("run_i0", 32'(i0), 32'(200 - 20 * (c / 4)));
                check("run_q", 32'(q), 32'(3 * (c / 4)));
                check("run_tick", 32'(step_tick), 1);
            end
            if (c == 39) check("done_early", 32'(sched_done), 0);
        end
        check("run_ticks", 32'(ticks), 10);
        check("run_done", 32'(sched_done), 1);

        // terminal hold
        ticks = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1);
            ticks += int'(step_tick);
        end
        check("term_ticks", 32'(ticks), 0);
        check("term_state", 32'(state_signal), 10);
        check("term_i0", 32'(i0), 0);
        check("term_q", 32'(q), 30);
        check("term_done", 32'(sched_done), 1);

        // pause / resume
        do_reset();
        comp_enable = 1'b1;
        cyc(6);
        check("pre_pause_state", 32'(state_signal), 1);
        comp_enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc(1);
            check("pause_state", 32'(state_signal), 1);
            check("pause_tick", 32'(step_tick), 0);
        end
        check("pause_i0", 32'(i0), 180);
        check("pause_q", 32'(q), 3);
        comp_enable = 1'b1;
        cyc(1);
        check("resume1_state", 32'(state_signal), 1);
        cyc(1);
        check("resume2_state", 32'(state_signal), 2);
        check("resume2_tick", 32'(step_tick), 1);
        check("resume2_i0", 32'(i0), 160);

        // enable dropped exactly on the last iteration of a phase
        cyc(3);
        check("toggle_pre", 32'(state_signal), 2);
        comp_enable = 1'b0;
        cyc(1);
        check("toggle_hold", 32'(state_signal), 2);
        check("toggle_hold_tick", 32'(step_tick), 0);
        comp_enable = 1'b1;
        cyc(1);
        check("toggle_adv", 32'(state_signal), 3);
        check("toggle_adv_tick", 32'(step_tick), 1);

        // mid-run reset at phase 5, iter 2
        do_reset();
        comp_enable = 1'b1;
        cyc(22);
        check("mid_state", 32'(state_signal), 5);
        rst_sys = 1'b1;
        cyc(1);
        check("midrst_state", 32'(state_signal), 0);
        check("midrst_i0", 32'(i0), 200);
        check("midrst_q", 32'(q), 0);
        check("midrst_tick", 32'(step_tick), 0);
        rst_sys = 1'b0;
        cyc(3);
        check("midrst_iter0", 32'(state_signal), 0);
        cyc(1);
        check("midrst_iter_adv", 32'(state_signal), 1);

        // saturation on the CYCLES_PER_STEP=1 instance
        do_reset();
        check("sat_rst_q", 32'(q_2), 250);
        comp_enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            check("sat_state", 32'(state2), 32'(k + 1));
            check("sat_i0", 32'(i0_2), 32'(sat_i0[k]));
            check("sat_q", 32'(q_2), 32'(sat_q[k]));
        end
        check("sat_done", 32'(done2), 1);
        cyc(1);
        check("sat_hold_state", 32'(state2), 10);
        check("sat_hold_tick", 32'(tick2), 0);

`ifdef ANNEAL_RUNTIME_CFG_EN
        cfg_i0_init = 8'd100;
        cfg_i0_dec  = 8'd10;
        do_reset();
        cyc(1);
        check("cfg_i0_p0", 32'(i0), 100);
        comp_enable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            cyc(1);
            if (c % 4 == 0) check("cfg_i0", 32'(i0), 32'(100 - 10 * (c / 4)));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/anneal_sched.md
# anneal_sched

Annealing schedule generator that sits directly downstream of the run controller. While `comp_enable` is high it counts spin-update iterations and advances a 4-bit schedule phase, `state_signal`, from 0 to 10. It produces the per-phase noise magnitude (`i0`) and coupling strength (`q`) consumed by the spin array. Phase 10 is terminal, and the controller uses it as its finish condition.

## Interface
Parameters:
- `CYCLES_PER_STEP`, 100: enabled cycles spent in each phase, ≥1.
- `I0_W`, 8: width of `i0`.
- `Q_W`, 8: width of `q`.
- `I0_INIT`, 8'd200: `i0` at phase 0.
- `I0_DEC`, 8'd20: `i0` decrement per phase.
- `Q_INIT`, 8'd0: `q` at phase 0.
- `Q_INC`, 8'd3: `q` increment per phase.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_sys`  in  1  reset, synchronous, active-high.
- `comp_enable`  in  1  run enable from the controller; the schedule advances only while high.
- `state_signal`  out  4  current phase, 0..10.
- `i0`  out  `I0_W`  noise magnitude for the current phase.
- `q`  out  `Q_W`  coupling strength for the current phase.
- `step_tick`  out  1  one-cycle pulse coincident with each new phase value.
- `sched_done`  out  1  high when `state_signal` is 10.

## Operation
- The internal iteration counter `iter` runs 0..`CYCLES_PER_STEP`-1.
- **Hold:** `comp_enable` low freezes `iter`, `state_signal`, `i0` and `q` (pause/resume), and `step_tick` is 0.
- **Count:** `comp_enable` high and `state_signal` < 10 increments `iter`.
- **Phase advance:** when `iter` equals `CYCLES_PER_STEP`-1 with `comp_enable` high, on the same edge:
  - `iter` is set to 0.
  - `state_signal` is incremented.
  - `i0` becomes max(`i0` − `I0_DEC`, 0).
  - `q` becomes min(`q` + `Q_INC`, 2^`Q_W`−1).
  - `step_tick` is set to 1.
- **Terminal phase:** at `state_signal` = 10, `iter` is frozen, no further ticks occur and all outputs hold regardless of `comp_enable`. Only reset leaves phase 10.
- **Arithmetic:** all unsigned. The saturation checks are done at widened width (one extra bit) so there is no wrap-around.
- **`CYCLES_PER_STEP` = 1:** the phase advances on every enabled cycle.
- **Counter width:** `iter` is max(1, $clog2(`CYCLES_PER_STEP`)) bits.

## Timing
- **Reset values:** `state_signal` = 0, `iter` = 0, `i0` = `I0_INIT`, `q` = `Q_INIT`, `step_tick` = 0, `sched_done` = 0. Reset overrides `comp_enable` and is honoured mid-run.
- **Registered outputs:** all outputs are registered; `sched_done` is decoded from the registered `state_signal`, so it carries no extra delay.
- **Phase latency:** phase k+1 appears one cycle after the k·`CYCLES_PER_STEP`-th … i.e. exactly `CYCLES_PER_STEP` enabled cycles after phase k appeared. `step_tick` is high in that same first cycle.
- **Total run:** phase 10 is reached after 10·`CYCLES_PER_STEP` enabled cycles from reset.
- **Controller overlap:** the controller drops `comp_enable` one cycle after phase 10. The freeze rule guarantees no increment in that overlap cycle.
- **Enable toggling:** if `comp_enable` drops in the cycle where `iter` = `CYCLES_PER_STEP`-1, no advance occurs. The advance happens on the next enabled cycle.

## Configuration
- Macro: `ANNEAL_RUNTIME_CFG_EN`.
- **Defined:** extra input ports `cfg_i0_init`[`I0_W`], `cfg_i0_dec`[`I0_W`] and `cfg_q_inc`[`Q_W`] are added.
  - They are latched into internal registers on every cycle in which `comp_enable` is low, `state_signal` = 0 and `iter` = 0.
  - `i0` is loaded from `cfg_i0_init` in those same cycles.
  - The latched values are used in place of `I0_INIT`, `I0_DEC` and `Q_INC`.
  - Reset loads the parameter values.
- **Undefined:** the ports are absent and the parameters are constants.

## Structure
- Package `anneal_pkg` holds:
  - `STEP_W` = 4.
  - `LAST_STEP` = 4'd10.
  - typedef `step_t` (logic [`STEP_W`-1:0]).
- The package is shared with the controller, which should compare against `LAST_STEP`.
- Sub-module `sched_iter_cnt` is the parameterised iteration counter.
  - Inputs: `clk`, `rst_sys`, enable, freeze.
  - Output: a wrap pulse.
- `anneal_sched` owns the phase, `i0` and `q` registers.

## Test plan
Tests 1–4 use default parameters except `CYCLES_PER_STEP` = 4.
1. Reset, then hold `comp_enable` = 1 for 40 cycles:
   - `state_signal` steps 1..10 every 4 cycles.
   - `i0` reads 200, 180, …, 0.
   - `q` reads 0, 3, …, 30.
   - Exactly 10 `step_tick` pulses; `sched_done` = 1 at cycle 40.
2. Pause: enable for 6 cycles, disable for 5, re-enable:
   - `state_signal` = 1 and outputs frozen during the pause.
   - Phase 2 appears 2 enabled cycles after resume.
3. Terminal hold: after reaching phase 10, keep `comp_enable` = 1 for 20 more cycles → no change and no ticks.
4. Mid-run reset: assert `rst_sys` at phase 5 with `iter` = 2 → the next cycle shows `state_signal` 0, `i0` 200, `q` 0, `step_tick` 0.
5. Saturation: `I0_DEC` = 30 and `Q_INIT` = 250 → `i0` reaches 0 at phase 7 and stays there; `q` saturates at 255 at phase 2.
6. With `ANNEAL_RUNTIME_CFG_EN`, idle and `cfg_i0_init` = 100, `cfg_i0_dec` = 10 → `i0` reads 100, 90, …, 0 across phases 0..10.
